// File: rtl/ifetch_ctrl.sv
// Instruction-fetch front end: owns the fetch PC, issues one bus request at a time,
// buffers the returned word while downstream holds, and squashes wrong-path responses.
module ifetch_ctrl #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] PC_RESET = 64'h0000_0000_8000_0000
) (
  input  logic            clk,
  input  logic            reset,
  output logic            ireq_valid,
  output logic [XLEN-1:0] ireq_addr,
  input  logic            iresp_data_ok,
  input  logic [31:0]     iresp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            hold,
  output logic [31:0]     raw_instr,
  output logic [XLEN-1:0] pc,
  output logic            stall,
  output logic            fetch_misalign
);

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    VALID = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] pc_q, pc_next;
  logic [XLEN-1:0] req_addr_q, req_addr_next;
  logic [31:0]     instr_q, instr_next;
  logic            mis_q, mis_next;
  logic            misaligned;
  logic            present;

  assign misaligned = (pc_q[1:0] != 2'b00);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= REQ;
      pc_q       <= PC_RESET;
      req_addr_q <= PC_RESET;
      instr_q    <= 32'd0;
      mis_q      <= 1'b0;
    end else begin
      state      <= state_next;
      pc_q       <= pc_next;
      req_addr_q <= req_addr_next;
      instr_q    <= instr_next;
      mis_q      <= mis_next;
    end
  end

  always_comb begin
    state_next    = state;
    pc_next       = pc_q;
    req_addr_next = req_addr_q;
    instr_next    = instr_q;
    mis_next      = mis_q;

    case (state)
      REQ: begin
        if (redirect_valid) begin
          pc_next = redirect_pc;
          // A misaligned PC never issued a request, so there is nothing to drain.
          state_next = (iresp_data_ok || misaligned) ? REQ : DROP;
        end else if (misaligned) begin
          instr_next = 32'd0;
          mis_next   = 1'b1;
          state_next = VALID;
        end else if (iresp_data_ok) begin
          instr_next = iresp_data;
          mis_next   = 1'b0;
          state_next = VALID;
        end
      end
      VALID: begin
        if (redirect_valid) begin
          pc_next    = redirect_pc;
          state_next = REQ;
        end else if (!hold) begin
          pc_next    = pc_q + XLEN'(4);
          state_next = REQ;
        end
      end
      DROP: begin
        if (redirect_valid) pc_next = redirect_pc;
        if (iresp_data_ok) state_next = REQ;
      end
      default: state_next = REQ;
    endcase

    // The request address is latched on entry to REQ so ireq_addr is stable for the whole request.
    if (state_next == REQ) req_addr_next = pc_next;
  end

  assign present        = (state == VALID) && !redirect_valid;
  assign ireq_valid     = reset && (((state == REQ) && !misaligned) || (state == DROP));
  assign ireq_addr      = req_addr_q;
  assign stall          = !present;
  assign raw_instr      = present ? instr_q : 32'd0;
  assign fetch_misalign = present && mis_q;
  assign pc             = pc_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Cycle-level vectors for ifetch_ctrl: each record drives one cycle of inputs and
// queues the outputs expected in that cycle; the sampler pops and compares them.
module tb_ifetch_ctrl;

  localparam logic [63:0] B = 64'h0000_0000_8000_0000;

  logic        clk;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        hold;
  logic [31:0] raw_instr;
  logic [63:0] pc;
  logic        stall;
  logic        fetch_misalign;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        rdv;
    logic [63:0] rpc;
    logic        hold;
    logic        ok;
    logic [31:0] data;
    logic        e_iv;
    logic [63:0] e_addr;
    logic        e_stall;
    logic [31:0] e_instr;
    logic [63:0] e_pc;
    logic        e_mis;
  } vec_t;

  vec_t tbl[24];
  vec_t exp_q[$];
  int   step_no = 0;

  ifetch_ctrl #(.XLEN(64), .PC_RESET(B)) dut (
    .clk            (clk),
    .reset          (reset),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .hold           (hold),
    .raw_instr      (raw_instr),
    .pc             (pc),
    .stall          (stall),
    .fetch_misalign (fetch_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t v(input logic rdv, input logic [63:0] rpc, input logic hd,
                             input logic ok, input logic [31:0] data,
                             input logic e_iv, input logic [63:0] e_addr, input logic e_stall,
                             input logic [31:0] e_instr, input logic [63:0] e_pc,
                             input logic e_mis);
    vec_t r;
    r.rdv = rdv; r.rpc = rpc; r.hold = hd; r.ok = ok; r.data = data;
    r.e_iv = e_iv; r.e_addr = e_addr; r.e_stall = e_stall;
    r.e_instr = e_instr; r.e_pc = e_pc; r.e_mis = e_mis;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL step %0d %s: got %h expected %h", step_no, name, act, exp);
    end
  endtask

  // Called at posedge+1: drive one cycle, compare at the falling edge, advance past the next rising edge.
  task automatic step(input vec_t t);
    vec_t e;
    redirect_valid = t.rdv;
    redirect_pc    = t.rpc;
    hold           = t.hold;
    iresp_data_ok  = t.ok;
    iresp_data     = t.data;
    exp_q.push_back(t);
    @(negedge clk);
    e = exp_q.pop_front();
    chk("ireq_valid", 64'(ireq_valid), 64'(e.e_iv));
    chk("ireq_addr", ireq_addr, e.e_addr);
    chk("stall", 64'(stall), 64'(e.e_stall));
    chk("raw_instr", 64'(raw_instr), 64'(e.e_instr));
    chk("pc", pc, e.e_pc);
    chk("fetch_misalign", 64'(fetch_misalign), 64'(e.e_mis));
    $display("step %0d: iv=%0b addr=%h stall=%0b instr=%h pc=%h mis=%0b",
             step_no, ireq_valid, ireq_addr, stall, raw_instr, pc, fetch_misalign);
    step_no++;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " ireq_valid"}, 64'(ireq_valid), 64'd0);
    chk({tag, " stall"}, 64'(stall), 64'd1);
    chk({tag, " raw_instr"}, 64'(raw_instr), 64'd0);
    chk({tag, " pc"}, pc, B);
    chk({tag, " fetch_misalign"}, 64'(fetch_misalign), 64'd0);
  endtask

  initial begin
    //         rdv rpc          hd ok data           iv addr        st instr          pc           mis
    tbl[0]  = v(0, 0,           0, 0, 0,             1, B,          1, 0,             B,           0);
    tbl[1]  = v(0, 0,           0, 1, 32'hA000_0001, 1, B,          1, 0,             B,           0);
    tbl[2]  = v(0, 0,           0, 0, 0,             0, B,          0, 32'hA000_0001, B,           0);
    tbl[3]  = v(0, 0,           0, 0, 0,             1, B+4,        1, 0,             B+4,         0);
    tbl[4]  = v(0, 0,           0, 1, 32'h0000_0013, 1, B+4,        1, 0,             B+4,         0);
    tbl[5]  = v(0, 0,           1, 0, 0,             0, B+4,        0, 32'h0000_0013, B+4,         0);
    tbl[6]  = v(0, 0,           1, 0, 0,             0, B+4,        0, 32'h0000_0013, B+4,         0);
    tbl[7]  = v(0, 0,           1, 0, 0,             0, B+4,        0, 32'h0000_0013, B+4,         0);
    tbl[8]  = v(0, 0,           0, 0, 0,             0, B+4,        0, 32'h0000_0013, B+4,         0);
    tbl[9]  = v(1, B+'h1000,    0, 0, 0,             1, B+8,        1, 0,             B+8,         0);
    tbl[10] = v(0, 0,           0, 0, 0,             1, B+8,        1, 0,             B+'h1000,    0);
    tbl[11] = v(0, 0,           0, 1, 32'hDEAD_BEEF, 1, B+8,        1, 0,             B+'h1000,    0);
    tbl[12] = v(0, 0,           0, 0, 0,             1, B+'h1000,   1, 0,             B+'h1000,    0);
    tbl[13] = v(0, 0,           0, 1, 32'hB000_0001, 1, B+'h1000,   1, 0,             B+'h1000,    0);
    tbl[14] = v(0, 0,           0, 0, 0,             0, B+'h1000,   0, 32'hB000_0001, B+'h1000,    0);
    tbl[15] = v(0, 0,           0, 0, 0,             1, B+'h1004,   1, 0,             B+'h1004,    0);
    tbl[16] = v(1, B+'h2000,    0, 1, 32'hCAFE_F00D, 1, B+'h1004,   1, 0,             B+'h1004,    0);
    tbl[17] = v(0, 0,           0, 0, 0,             1, B+'h2000,   1, 0,             B+'h2000,    0);
    tbl[18] = v(0, 0,           0, 1, 32'hB000_0002, 1, B+'h2000,   1, 0,             B+'h2000,    0);
    tbl[19] = v(1, B+2,         0, 0, 0,             0, B+'h2000,   1, 0,             B+'h2000,    0);
    tbl[20] = v(0, 0,           0, 0, 0,             0, B+2,        1, 0,             B+2,         0);
    tbl[21] = v(0, 0,           1, 0, 0,             0, B+2,        0, 0,             B+2,         1);
    tbl[22] = v(1, B+'h3000,    1, 0, 0,             0, B+2,        1, 0,             B+2,         0);
    tbl[23] = v(0, 0,           0, 0, 0,             1, B+'h3000,   1, 0,             B+'h3000,    0);

    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; hold = 1'b0;
    iresp_data_ok = 1'b0; iresp_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("in_reset");
    @(posedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < 24; i++) step(tbl[i]);

    // PC wrap: redirect to the top word while a request is in flight, then consume it.
    step(v(1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0,             1, B+'h3000, 1, 0, B+'h3000, 0));
    step(v(0, 0, 0, 1, 32'h1234_5678,                       1, B+'h3000, 1, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0));
    step(v(0, 0, 0, 1, 32'hC000_0003,                       1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0));
    step(v(0, 0, 0, 0, 0,                                   0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 32'hC000_0003, 64'hFFFF_FFFF_FFFF_FFFC, 0));
    step(v(0, 0, 0, 0, 0,                                   1, 64'd0, 1, 0, 64'd0, 0));

    // Asynchronous reset while the request for address 0 is outstanding.
    reset = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    chk("async_reset ireq_addr", ireq_addr, B);
    @(posedge clk); #1;
    reset = 1'b1;
    step(v(0, 0, 0, 0, 0,             1, B, 1, 0, B, 0));
    step(v(0, 0, 0, 1, 32'hD000_0004, 1, B, 1, 0, B, 0));
    step(v(0, 0, 0, 0, 0,             0, B, 0, 32'hD000_0004, B, 0));
    step(v(0, 0, 0, 0, 0,             1, B+4, 1, 0, B+4, 0));

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
